// File: rtl/led_arb_pkg.sv
// Shared types and constants for the two-requester LED register arbiter.
package led_arb_pkg;

  // Default width of the LED register data path.
  localparam int DW_DEFAULT = 8;

  // Largest supported LED register read latency, in cycles.
  localparam int RD_LAT_MAX = 4;

  // Arbiter transaction states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RWAIT = 3'd3,
    ACK   = 3'd4
  } arb_state_t;

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  // The requester that is not 'id'.
  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Two-way round-robin selector: grants the sole requester, or the one that
// was not granted last when both ask in the same cycle.
module led_rr_pick
  import led_arb_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  req_id_t    last_grant_i,
  output logic [1:0] grant_o,
  output req_id_t    winner_o
);

  // Winner selection; an empty grant vector means nobody is asking.
  always_comb begin
    grant_o  = 2'b00;
    winner_o = 1'b0;
    if (valid0_i && valid1_i) begin
      winner_o = other_id(last_grant_i);
      grant_o  = (winner_o == 1'b1) ? 2'b10 : 2'b01;
    end else if (valid0_i) begin
      winner_o = 1'b0;
      grant_o  = 2'b01;
    end else if (valid1_i) begin
      winner_o = 1'b1;
      grant_o  = 2'b10;
    end
  end

endmodule

// File: rtl/led_bus_arb.sv
// Arbiter that shares one LED register port between two requesters.
// Each accepted request runs to completion (write or read with a fixed
// read latency) before the next is accepted; grants alternate on contention.
module led_bus_arb
  import led_arb_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  // Cycles from led_rd_en to valid led_data_out; legal range 1..RD_LAT_MAX.
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_rnw,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_ack,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_rnw,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_ack,
  output logic [DW-1:0] req1_rdata,
  output logic          led_wr_en,
  output logic          led_rd_en,
  output logic [DW-1:0] led_data_in,
  input  logic [DW-1:0] led_data_out,
  output logic          busy
);

  // Index of the final RWAIT cycle, where the read data is captured.
  localparam logic [1:0] RWAIT_LAST = 2'(RD_LAT - 1);

  arb_state_t    state_q, state_d;
  req_id_t       id_q, id_d;
  req_id_t       lastGrant_q, lastGrant_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] ledDataIn_q, ledDataIn_d;
  logic          ledWrEn_q, ledRdEn_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic [1:0]    grant;
  req_id_t       winner;
  logic          accept;
  logic          winnerRnw;
  logic          rwaitDone;

  led_rr_pick u_pick (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (lastGrant_q),
    .grant_o      (grant),
    .winner_o     (winner)
  );

  // FSM state plus the captured transaction context and last-grant memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      lastGrant_q <= 1'b1;
      cnt_q       <= '0;
      ledDataIn_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
      ledDataIn_q <= ledDataIn_d;
    end
  end

  // Next-state logic: accept in IDLE, then walk the write or read sequence.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    lastGrant_d = lastGrant_q;
    cnt_d       = cnt_q;
    ledDataIn_d = ledDataIn_q;
    accept      = 1'b0;
    winnerRnw   = 1'b0;
    rwaitDone   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          accept      = 1'b1;
          id_d        = winner;
          lastGrant_d = winner;
          winnerRnw   = (winner == 1'b1) ? req1_rnw : req0_rnw;
          if (winnerRnw) begin
            state_d = READ;
          end else begin
            state_d     = WRITE;
            ledDataIn_d = (winner == 1'b1) ? req1_wdata : req0_wdata;
          end
        end
      end
      WRITE: begin
        state_d = ACK;
      end
      READ: begin
        state_d = RWAIT;
        cnt_d   = '0;
      end
      RWAIT: begin
        if (cnt_q == RWAIT_LAST) begin
          rwaitDone = 1'b1;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus strobes are registered so they line up exactly with WRITE and READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledWrEn_q <= 1'b0;
      ledRdEn_q <= 1'b0;
    end else begin
      ledWrEn_q <= (state_d == WRITE);
      ledRdEn_q <= (state_d == READ);
    end
  end

  // Per-requester read results, updated only on that requester's reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (rwaitDone) begin
      if (id_q == 1'b0) begin
        rdata0_q <= led_data_out;
      end else begin
        rdata1_q <= led_data_out;
      end
    end
  end

  // Ready is combinational in IDLE and must stay low while reset is held.
  assign req0_ready  = accept & grant[0] & ~reset;
  assign req1_ready  = accept & grant[1] & ~reset;
  assign req0_ack    = (state_q == ACK) && (id_q == 1'b0);
  assign req1_ack    = (state_q == ACK) && (id_q == 1'b1);
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign led_wr_en   = ledWrEn_q;
  assign led_rd_en   = ledRdEn_q;
  assign led_data_in = ledDataIn_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_led_bus_arb.sv
// Self-checking bench for led_bus_arb. Two instances (read latency 1 and 3)
// share stimulus; 'sel' picks which one is live. Expectations come from a
// transaction-level model that schedules strobes/acks by cycle arithmetic.
module tb_led_bus_arb;

  localparam int DW = 8;

  typedef struct packed {
    logic          rnw;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [1:0]    ready;
    logic [1:0]    ack;
    logic          wrEn;
    logic          rdEn;
    logic          busy;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
  } outs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sel = 1'b0;
  logic          req0Valid = 1'b0, req1Valid = 1'b0;
  logic          req0Rnw = 1'b0, req1Rnw = 1'b0;
  logic [DW-1:0] req0Wdata = '0, req1Wdata = '0, ledOut = '0;

  logic [1:0]    vld0, vld1, rdy0, rdy1, ack0, ack1, wrEn, rdEn, busy;
  logic [DW-1:0] rdata0 [2];
  logic [DW-1:0] rdata1 [2];
  logic [DW-1:0] dataIn [2];

  assign vld0[0] = req0Valid & ~sel;
  assign vld0[1] = req0Valid & sel;
  assign vld1[0] = req1Valid & ~sel;
  assign vld1[1] = req1Valid & sel;

  led_bus_arb #(.DW(DW), .RD_LAT(1)) dutLat1 (
    .clk(clk), .reset(reset),
    .req0_valid(vld0[0]), .req0_rnw(req0Rnw), .req0_wdata(req0Wdata),
    .req0_ready(rdy0[0]), .req0_ack(ack0[0]), .req0_rdata(rdata0[0]),
    .req1_valid(vld1[0]), .req1_rnw(req1Rnw), .req1_wdata(req1Wdata),
    .req1_ready(rdy1[0]), .req1_ack(ack1[0]), .req1_rdata(rdata1[0]),
    .led_wr_en(wrEn[0]), .led_rd_en(rdEn[0]), .led_data_in(dataIn[0]),
    .led_data_out(ledOut), .busy(busy[0])
  );

  led_bus_arb #(.DW(DW), .RD_LAT(3)) dutLat3 (
    .clk(clk), .reset(reset),
    .req0_valid(vld0[1]), .req0_rnw(req0Rnw), .req0_wdata(req0Wdata),
    .req0_ready(rdy0[1]), .req0_ack(ack0[1]), .req0_rdata(rdata0[1]),
    .req1_valid(vld1[1]), .req1_rnw(req1Rnw), .req1_wdata(req1Wdata),
    .req1_ready(rdy1[1]), .req1_ack(ack1[1]), .req1_rdata(rdata1[1]),
    .led_wr_en(wrEn[1]), .led_rd_en(rdEn[1]), .led_data_in(dataIn[1]),
    .led_data_out(ledOut), .busy(busy[1])
  );

  always #5 clk = ~clk;

  // Cycle number; cycle k spans posedge k to posedge k+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  req_t          q0[$];
  req_t          q1[$];
  logic [DW-1:0] ledLog [0:8191];
  bit            fixedData = 1'b0;
  logic [DW-1:0] fixedVal = '0;

  // Reference model state.
  bit            mActive = 1'b0;
  bit            mId = 1'b0;
  bit            mRnw = 1'b0;
  logic [DW-1:0] mWdata = '0;
  int            mAcc = 0, mAck = -1, mWr = -1, mRd = -1, mSample = -1;
  bit            mLast [2];
  logic [DW-1:0] mDataIn [2];
  logic [DW-1:0] mRdata [2][2];
  outs_t         expOut;

  // Transaction-level model: one outstanding transaction at a time; write
  // strobe at acc+1, ack at acc+2; read strobe at acc+1, data sampled at
  // acc+1+lat, ack at acc+2+lat.
  task automatic model_cycle(input int k);
    int lat;
    lat = sel ? 3 : 1;
    expOut = '0;
    if (reset) begin
      mActive = 1'b0;
      for (int d = 0; d < 2; d++) begin
        mLast[d] = 1'b1;
        mDataIn[d] = '0;
        mRdata[d][0] = '0;
        mRdata[d][1] = '0;
      end
      return;
    end
    if (mActive && k > mAck) mActive = 1'b0;
    if (!mActive && (req0Valid || req1Valid)) begin
      if (req0Valid && req1Valid) mId = !mLast[sel];
      else mId = req1Valid;
      mLast[sel] = mId;
      mActive = 1'b1;
      mAcc = k;
      mRnw = mId ? req1Rnw : req0Rnw;
      mWdata = mId ? req1Wdata : req0Wdata;
      mWr = mRnw ? -1 : k + 1;
      mRd = mRnw ? k + 1 : -1;
      mSample = k + 1 + lat;
      mAck = mRnw ? k + 2 + lat : k + 2;
      expOut.ready[mId] = 1'b1;
    end
    if (mActive && k == mWr) mDataIn[sel] = mWdata;
    if (mActive && mRnw && k == mAck) mRdata[sel][mId] = ledLog[mSample % 8192];
    expOut.wrEn = mActive && (k == mWr);
    expOut.rdEn = mActive && (k == mRd);
    if (mActive && k == mAck) expOut.ack[mId] = 1'b1;
    expOut.busy = mActive && (k > mAcc);
    expOut.dataIn = mDataIn[sel];
    expOut.rdata0 = mRdata[sel][0];
    expOut.rdata1 = mRdata[sel][1];
  endtask

  function automatic outs_t observe();
    outs_t o;
    o.ready  = {rdy1[sel], rdy0[sel]};
    o.ack    = {ack1[sel], ack0[sel]};
    o.wrEn   = wrEn[sel];
    o.rdEn   = rdEn[sel];
    o.busy   = busy[sel];
    o.dataIn = dataIn[sel];
    o.rdata0 = rdata0[sel];
    o.rdata1 = rdata1[sel];
    return o;
  endfunction

  // Drive one cycle's inputs at the falling edge, then evaluate the model.
  task automatic cycle_begin(input logic rstVal);
    @(negedge clk);
    reset = rstVal;
    req0Valid = (q0.size() > 0);
    if (q0.size() > 0) begin
      req0Rnw = q0[0].rnw;
      req0Wdata = q0[0].wdata;
    end
    req1Valid = (q1.size() > 0);
    if (q1.size() > 0) begin
      req1Rnw = q1[0].rnw;
      req1Wdata = q1[0].wdata;
    end
    ledOut = fixedData ? fixedVal : DW'($urandom);
    ledLog[cyc % 8192] = ledOut;
    #1;
    model_cycle(cyc);
  endtask

  // Requesters retire their head entry once it is accepted.
  task automatic cycle_end();
    if (rdy0[sel] && q0.size() > 0) void'(q0.pop_front());
    if (rdy1[sel] && q1.size() > 0) void'(q1.pop_front());
  endtask

  function automatic req_t mkReq(input logic rnw, input logic [DW-1:0] wdata);
    req_t r;
    r.rnw = rnw;
    r.wdata = wdata;
    return r;
  endfunction

  task automatic test_reset();
    outs_t o;
    sel = 1'b0;
    q0.push_back(mkReq(1'b0, 8'h3C));
    q1.push_back(mkReq(1'b1, 8'hC3));
    repeat (3) begin
      cycle_begin(1'b1);
      o = observe();
      checks++;
      if (o !== expOut) begin
        failures++;
        $display("[TB] FAIL reset_outputs cyc %0d: got %h required %h", cyc, o, expOut);
      end
      cycle_end();
    end
    q0.delete();
    q1.delete();
    cycle_begin(1'b0);
    o = observe();
    checks++;
    if (o !== expOut) begin
      failures++;
      $display("[TB] FAIL reset_release cyc %0d: got %h required %h", cyc, o, expOut);
    end
    cycle_end();
  endtask

  task automatic test_single_write();
    outs_t o;
    sel = 1'b0;
    q0.push_back(mkReq(1'b0, 8'hAA));
    repeat (5) begin
      cycle_begin(1'b0);
      o = observe();
      checks++;
      if (o !== expOut) begin
        failures++;
        $display("[TB] FAIL single_write cyc %0d: got %h required %h", cyc, o, expOut);
      end
      cycle_end();
    end
    checks++;
    if (dataIn[0] !== 8'hAA) begin
      failures++;
      $display("[TB] FAIL single_write_hold: got %h required aa", dataIn[0]);
    end
  endtask

  task automatic test_single_read();
    outs_t o;
    sel = 1'b0;
    fixedData = 1'b1;
    fixedVal = 8'h5A;
    q1.push_back(mkReq(1'b1, 8'h00));
    repeat (6) begin
      cycle_begin(1'b0);
      o = observe();
      checks++;
      if (o !== expOut) begin
        failures++;
        $display("[TB] FAIL single_read cyc %0d: got %h required %h", cyc, o, expOut);
      end
      cycle_end();
    end
    fixedData = 1'b0;
    checks++;
    if (rdata1[0] !== 8'h5A || rdata0[0] !== 8'h00) begin
      failures++;
      $display("[TB] FAIL single_read_rdata: got %h/%h required 00/5a", rdata0[0], rdata1[0]);
    end
  endtask

  task automatic test_contention();
    outs_t o;
    logic [DW-1:0] seen[$];
    logic [DW-1:0] wantOrder [4];
    wantOrder[0] = 8'h11;
    wantOrder[1] = 8'h22;
    wantOrder[2] = 8'h33;
    wantOrder[3] = 8'h44;
    sel = 1'b0;
    cycle_begin(1'b1);
    cycle_end();
    q0.push_back(mkReq(1'b0, 8'h11));
    q0.push_back(mkReq(1'b0, 8'h33));
    q1.push_back(mkReq(1'b0, 8'h22));
    q1.push_back(mkReq(1'b0, 8'h44));
    repeat (14) begin
      cycle_begin(1'b0);
      o = observe();
      checks++;
      if (o !== expOut) begin
        failures++;
        $display("[TB] FAIL contention cyc %0d: got %h required %h", cyc, o, expOut);
      end
      if (o.wrEn) seen.push_back(o.dataIn);
      cycle_end();
    end
    checks++;
    if (seen.size() != 4) begin
      failures++;
      $display("[TB] FAIL contention_count: got %0d writes required 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== wantOrder[i]) begin
          failures++;
          $display("[TB] FAIL contention_order[%0d]: got %h required %h", i, seen[i], wantOrder[i]);
        end
      end
    end
  endtask

  task automatic test_withdraw();
    outs_t o;
    int wrCount = 0;
    int req1Seen = 0;
    sel = 1'b0;
    q0.push_back(mkReq(1'b0, 8'h55));
    q1.push_back(mkReq(1'b0, 8'h66));
    for (int c = 0; c < 7; c++) begin
      if (c == 1) q1.delete();
      cycle_begin(1'b0);
      o = observe();
      checks++;
      if (o !== expOut) begin
        failures++;
        $display("[TB] FAIL withdraw cyc %0d: got %h required %h", cyc, o, expOut);
      end
      if (o.wrEn) wrCount++;
      if (o.ready[1] || o.ack[1]) req1Seen++;
      cycle_end();
    end
    checks++;
    if (wrCount != 1 || req1Seen != 0) begin
      failures++;
      $display("[TB] FAIL withdraw_activity: got %0d writes %0d req1 events required 1 and 0", wrCount, req1Seen);
    end
  endtask

  task automatic test_reset_rwait();
    outs_t o;
    int ack0After = 0;
    int ack1Count = 0;
    sel = 1'b1;
    q0.push_back(mkReq(1'b1, 8'h00));
    for (int c = 0; c < 13; c++) begin
      if (c == 7) q1.push_back(mkReq(1'b0, 8'h77));
      cycle_begin((c == 3 || c == 4) ? 1'b1 : 1'b0);
      o = observe();
      checks++;
      if (o !== expOut) begin
        failures++;
        $display("[TB] FAIL reset_rwait cyc %0d: got %h required %h", cyc, o, expOut);
      end
      if (c >= 3 && o.ack[0]) ack0After++;
      if (o.ack[1]) ack1Count++;
      cycle_end();
    end
    checks++;
    if (ack0After != 0 || ack1Count != 1 || dataIn[1] !== 8'h77) begin
      failures++;
      $display("[TB] FAIL reset_rwait_after: got ack0 %0d ack1 %0d data %h required 0 1 77", ack0After, ack1Count, dataIn[1]);
    end
  endtask

  task automatic test_rdlat3();
    outs_t o;
    int accCyc = -1;
    int ackCyc = -1;
    sel = 1'b1;
    q1.push_back(mkReq(1'b1, 8'h00));
    repeat (8) begin
      cycle_begin(1'b0);
      o = observe();
      checks++;
      if (o !== expOut) begin
        failures++;
        $display("[TB] FAIL rdlat3 cyc %0d: got %h required %h", cyc, o, expOut);
      end
      if (o.ready[1]) accCyc = cyc;
      if (o.ack[1]) ackCyc = cyc;
      cycle_end();
    end
    checks++;
    if (accCyc < 0 || ackCyc - accCyc != 5) begin
      failures++;
      $display("[TB] FAIL rdlat3_latency: got %0d cycles required 5", ackCyc - accCyc);
    end else begin
      checks++;
      if (rdata1[1] !== ledLog[(accCyc + 4) % 8192]) begin
        failures++;
        $display("[TB] FAIL rdlat3_sample: got %h required %h", rdata1[1], ledLog[(accCyc + 4) % 8192]);
      end
    end
  endtask

  task automatic test_random();
    outs_t o;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int c = 0; c < 240; c++) begin
        if (c < 200) begin
          if (q0.size() < 3 && $urandom_range(0, 3) == 0)
            q0.push_back(mkReq(1'($urandom), DW'($urandom)));
          if (q1.size() < 3 && $urandom_range(0, 3) == 0)
            q1.push_back(mkReq(1'($urandom), DW'($urandom)));
          if ($urandom_range(0, 39) == 0) q1.delete();
        end
        cycle_begin(1'b0);
        o = observe();
        checks++;
        if (o !== expOut) begin
          failures++;
          $display("[TB] FAIL random_lat%0d cyc %0d: got %h required %h", d * 2 + 1, cyc, o, expOut);
        end
        cycle_end();
      end
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
        failures++;
        $display("[TB] FAIL random_drain: got %0d/%0d pending required 0/0", q0.size(), q1.size());
        q0.delete();
        q1.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_withdraw();
    test_reset_rwait();
    test_rdlat3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
